// File: rtl/adder_share_arbiter.sv
// Shares one fixed-latency pipelined 4-bit adder between NREQ requesters using
// round-robin grants, per-requester credit limits and an ID-tagged shadow pipeline.
module adder_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int LAT     = 8,
    parameter int MAX_OUT = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [4*NREQ-1:0]          req_a,
    input  logic [4*NREQ-1:0]          req_b,
    input  logic [NREQ-1:0]            req_cin,
    output logic [NREQ-1:0]            req_ready,
    output logic [3:0]                 add_a,
    output logic [3:0]                 add_b,
    output logic                       add_cin,
    input  logic [3:0]                 add_s,
    input  logic                       add_cout,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [4:0]                 rsp_sum,
    output logic [$clog2(LAT+1)-1:0]   inflight,
    output logic                       busy
);

    localparam int ID_W = $clog2(NREQ);
    localparam int IF_W = $clog2(LAT+1);
    localparam int CR_W = $clog2(MAX_OUT+1);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    tag_t             r_tag [LAT];
    logic [CR_W-1:0]  r_credit [NREQ];
    logic [ID_W-1:0]  r_ptr;
    logic [IF_W-1:0]  r_inflight;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [4:0]       r_rsp_sum;

    logic [NREQ-1:0]  w_eligible;
    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_inc;
    logic [NREQ-1:0]  w_dec;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W-1:0]  w_idx;
    logic             w_hs;
    int               w_sum;
    tag_t             w_retire;

    assign w_retire = r_tag[LAT-1];

    // Gating with rstn keeps grants and adder operands quiet throughout reset.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_eligible[i] = rstn && req_valid[i] && (r_credit[i] < CR_W'(MAX_OUT));
        end
    end

    // NOTE: always_comb uses blocking '=' so later statements see earlier updates;
    // every output gets a default first so no path can leave a latch behind.
    always_comb begin
        w_hs     = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        w_sum    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NREQ) w_sum = w_sum - NREQ;
            w_idx = ID_W'(w_sum);
            if (!w_hs && w_eligible[w_idx]) begin
                w_hs     = 1'b1;
                w_gnt_id = w_idx;
            end
        end
        w_grant = w_hs ? (NREQ'(1) << w_gnt_id) : '0;
    end

    assign req_ready = w_grant;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (w_hs) begin
            add_a   = req_a[4*w_gnt_id +: 4];
            add_b   = req_b[4*w_gnt_id +: 4];
            add_cin = req_cin[w_gnt_id];
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_inc[i] = w_grant[i];
            w_dec[i] = w_retire.vld && (w_retire.id == ID_W'(i));
        end
    end

    // NOTE: the tag pipeline is reset explicitly; dropping every valid bit is what
    // suppresses responses for operations issued before a reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= {w_hs, w_gnt_id};
            for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) r_credit[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_credit[i] <= r_credit[i] + CR_W'(1);
                    2'b01:   r_credit[i] <= r_credit[i] - CR_W'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr      <= '0;
            r_inflight <= '0;
        end else begin
            if (w_hs) begin
                r_ptr <= (w_gnt_id == ID_W'(NREQ-1)) ? '0 : w_gnt_id + ID_W'(1);
            end
            case ({w_hs, w_retire.vld})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
        end else begin
            r_rsp_valid <= w_retire.vld;
            if (w_retire.vld) begin
                r_rsp_id  <= w_retire.id;
                r_rsp_sum <= {add_cout, add_s};
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign inflight  = r_inflight;
    assign busy      = (r_inflight != '0) || r_rsp_valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_credit_chk
            a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
                r_credit[gi] <= CR_W'(MAX_OUT));
            a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
                !(w_dec[gi] && !w_inc[gi] && (r_credit[gi] == '0)));
        end
    endgenerate

    a_inflight_max: assert property (@(posedge clk) disable iff (!rstn)
        r_inflight <= IF_W'(LAT));

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: a queue-based arbitration/credit model
// predicts grants and responses; a separate monitor checks every response.
module tb_adder_share_arbiter;

    localparam int NREQ    = 4;
    localparam int LAT     = 8;
    localparam int MAX_OUT = 2;
    localparam int ID_W    = $clog2(NREQ);
    localparam int IF_W    = $clog2(LAT+1);

    logic                clk;
    logic                rstn;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_a;
    logic [4*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_cin;
    logic [NREQ-1:0]     req_ready;
    logic [3:0]          add_a;
    logic [3:0]          add_b;
    logic                add_cin;
    logic [3:0]          add_s;
    logic                add_cout;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [4:0]          rsp_sum;
    logic [IF_W-1:0]     inflight;
    logic                busy;

    adder_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .inflight(inflight), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Shared adder: samples operands at a posedge, result visible LAT edges later.
    // It is deliberately not reset, so stale results keep flowing after a reset.
    logic [4:0] adder_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) adder_pipe[i] = '0;
    always @(posedge clk) begin
        adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
        for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
    assign add_s    = adder_pipe[LAT-1][3:0];
    assign add_cout = adder_pipe[LAT-1][4];

    typedef struct { int id; int sum; int due; } exp_t;
    typedef struct { int id; int issue; } fl_t;
    exp_t sb_q [$];
    fl_t  fl_q [$];
    int   m_ptr;
    int   m_credit [NREQ];

    logic [3:0] s_a [NREQ];
    logic [3:0] s_b [NREQ];
    logic       s_cin [NREQ];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        fl_q.delete();
        sb_q.delete();
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) m_credit[i] = 0;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < NREQ; i++) begin
            s_a[i]   = 4'($urandom_range(0, 15));
            s_b[i]   = 4'($urandom_range(0, 15));
            s_cin[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock cycle: drive requests, then predict and check grant, operands and counters.
    task automatic drive_cycle(input logic [NREQ-1:0] v);
        int   g;
        int   idx;
        bit   rsp_now;
        exp_t e;
        fl_t  f;
        @(negedge clk);
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[4*i +: 4] = s_a[i];
            req_b[4*i +: 4] = s_b[i];
            req_cin[i]      = s_cin[i];
        end
        #1;
        rsp_now = 1'b0;
        while (fl_q.size() > 0 && fl_q[0].issue + LAT < cyc) begin
            if (fl_q[0].issue + LAT + 1 == cyc) rsp_now = 1'b1;
            m_credit[fl_q[0].id]--;
            void'(fl_q.pop_front());
        end
        check("inflight", 32'(inflight), 32'(fl_q.size()));
        check("busy", 32'(busy), 32'((fl_q.size() != 0) || rsp_now));
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && v[idx] && m_credit[idx] < MAX_OUT) g = idx;
        end
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
            check("add_operands", {23'd0, add_cin, add_b, add_a}, {23'd0, s_cin[g], s_b[g], s_a[g]});
            e.id  = g;
            e.sum = int'(s_a[g]) + int'(s_b[g]) + int'(s_cin[g]);
            e.due = cyc + LAT + 1;
            sb_q.push_back(e);
            f.id    = g;
            f.issue = cyc;
            fl_q.push_back(f);
            m_credit[g]++;
            m_ptr = (g + 1) % NREQ;
        end else begin
            check("add_idle_zero", {23'd0, add_cin, add_b, add_a}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = '0;
        model_clear();
        #1;
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: every response pulse must match the oldest expected entry, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("rsp_spurious", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                check("rsp_missing", 32'(rsp_valid), 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        randomize_operands();
        rstn      = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[4*i +: 4] = s_a[i];
            req_b[4*i +: 4] = s_b[i];
            req_cin[i]      = s_cin[i];
        end
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_add", {23'd0, add_cin, add_b, add_a}, 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_inflight", 32'(inflight), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        req_valid = '0;
        rstn      = 1'b1;

        // Single operation from requester 1: 3 + 5 -> 5'b01000.
        idle(2);
        s_a[1] = 4'd3; s_b[1] = 4'd5; s_cin[1] = 1'b0;
        drive_cycle(4'b0010);
        idle(LAT + 3);

        // Overflow from requester 0: 15+15+1 then 8+8.
        s_a[0] = 4'd15; s_b[0] = 4'd15; s_cin[0] = 1'b1;
        drive_cycle(4'b0001);
        s_a[0] = 4'd8; s_b[0] = 4'd8; s_cin[0] = 1'b0;
        drive_cycle(4'b0001);
        idle(LAT + 3);

        // All four requesters: round-robin until credits run out, then wait for retirement.
        for (int i = 0; i < LAT + 6; i++) begin
            randomize_operands();
            drive_cycle(4'b1111);
        end
        idle(LAT + 3);

        // Credit limit with a single active requester.
        for (int i = 0; i < 3 * LAT; i++) begin
            randomize_operands();
            drive_cycle(4'b0100);
        end
        idle(LAT + 3);

        // Alternating valid and idle cycles.
        for (int i = 0; i < 16; i++) begin
            randomize_operands();
            drive_cycle((i % 2 == 0) ? 4'b1000 : 4'b0000);
        end
        idle(LAT + 3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_operands();
            drive_cycle(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
        end
        idle(LAT + 3);

        // Reset in the middle of three outstanding operations.
        randomize_operands();
        drive_cycle(4'b0001);
        drive_cycle(4'b0010);
        drive_cycle(4'b0100);
        idle(1);
        pulse_reset();
        idle(LAT + 4);
        randomize_operands();
        drive_cycle(4'b0010);
        idle(LAT + 4);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
